// File: rtl/icache_fetch_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder_pkg
// Shared types and geometry constants for the instruction-fetch responder
// (direct-mapped read-only I-cache with a 4 x 64-bit burst line fill).
//   icache_state_t : controller states CHECK / FILL
//   icache_line_t  : one 256-bit cache line
//   tag_w()        : tag width for a given number of index bits
// No ports (package). Optional feature macro used by the top: ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
package icache_fetch_responder_pkg;

    localparam int S_INDEX_DEF = 3;                    // default index bits
    localparam int S_OFFSET    = 5;                    // fixed 32-byte line
    localparam int BURST_LEN   = 4;                    // beats per line fill
    localparam int BEAT_W      = 64;                   // bits per beat
    localparam int WORD_W      = 32;                   // instruction word
    localparam int LINE_W      = BURST_LEN * BEAT_W;   // 256-bit line

    typedef logic [LINE_W-1:0] icache_line_t;

    typedef enum logic {
        CHECK = 1'b0,
        FILL  = 1'b1
    } icache_state_t;

    function automatic int tag_w(input int s_index);
        return 32 - S_OFFSET - s_index;
    endfunction

    localparam int TAG_W_DEF   = tag_w(S_INDEX_DEF);
    localparam int INDEX_W_DEF = S_INDEX_DEF;
    localparam int OFFSET_W    = S_OFFSET;

endpackage

// File: rtl/icache_fetch_responder_datapath.sv
// -----------------------------------------------------------------------------
// icache_datapath
// Storage and lookup side of the I-cache: per-set valid/tag/data flops, the
// line fill buffer, the hit comparator and the instruction word mux.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   lookup_addr     : fetch address bits [31:2]
//   lookup_read     : lookup qualifier (read strobe while in CHECK)
//   hit, rdata      : combinational hit and selected 32-bit word
//   beat_we/idx/data: one burst beat into the fill buffer
//   line_we         : commit the assembled line into the set of fill_line_addr
//   fill_line_addr  : latched line address of the fill in progress
//   clear_all       : invalidate every set (wins over a same-cycle commit)
// -----------------------------------------------------------------------------
module icache_datapath
    import icache_fetch_responder_pkg::*;
#(
    parameter int S_INDEX = S_INDEX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:2]           lookup_addr,
    input  logic                  lookup_read,
    output logic                  hit,
    output logic [WORD_W-1:0]     rdata,
    input  logic                  beat_we,
    input  logic [1:0]            beat_idx,
    input  logic [BEAT_W-1:0]     beat_data,
    input  logic                  line_we,
    input  logic [31:S_OFFSET]    fill_line_addr,
    input  logic                  clear_all
);

    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = tag_w(S_INDEX);

    logic [TAG_W-1:0]   lk_tag;
    logic [S_INDEX-1:0] lk_index;
    logic [2:0]         lk_word;
    logic [TAG_W-1:0]   fl_tag;
    logic [S_INDEX-1:0] fl_index;

    assign lk_tag   = lookup_addr[31:S_OFFSET+S_INDEX];
    assign lk_index = lookup_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign lk_word  = lookup_addr[4:2];
    assign fl_tag   = fill_line_addr[31:S_OFFSET+S_INDEX];
    assign fl_index = fill_line_addr[S_OFFSET+S_INDEX-1:S_OFFSET];

    // Assembled line: the last beat is forwarded straight into the line so the
    // commit happens in the same cycle the final beat arrives.
    icache_line_t fill_line;

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            logic [BEAT_W-1:0] buf_q;
            logic [BEAT_W-1:0] buf_d;
            logic              sel;

            assign sel = beat_we && (beat_idx == 2'(gi));

            always_comb begin
                buf_d = buf_q;
                if (sel) begin
                    buf_d = beat_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_q <= '0;
                end else begin
                    buf_q <= buf_d;
                end
            end

            assign fill_line[BEAT_W*gi +: BEAT_W] = sel ? beat_data : buf_q;
        end
    endgenerate

    logic               set_valid [SETS];
    logic [TAG_W-1:0]   set_tag   [SETS];
    icache_line_t       set_data  [SETS];

    generate
        for (gi = 0; gi < SETS; gi++) begin : g_set
            logic             valid_q, valid_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            icache_line_t     data_q, data_d;
            logic             wr;

            assign wr = line_we && (fl_index == S_INDEX'(gi));

            always_comb begin
                valid_d = valid_q;
                tag_d   = tag_q;
                data_d  = data_q;
                if (wr) begin
                    valid_d = 1'b1;
                    tag_d   = fl_tag;
                    data_d  = fill_line;
                end
                // A flush pending at fill completion also drops the new line.
                if (clear_all) begin
                    valid_d = 1'b0;
                end
            end

            // Tags and data are reset too so the word mux never shows X.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    tag_q   <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                    data_q  <= data_d;
                end
            end

            assign set_valid[gi] = valid_q;
            assign set_tag[gi]   = tag_q;
            assign set_data[gi]  = data_q;
        end
    endgenerate

    icache_line_t sel_line;
    assign sel_line = set_data[lk_index];
    assign rdata    = sel_line[WORD_W*lk_word +: WORD_W];
    assign hit      = lookup_read && set_valid[lk_index] && (set_tag[lk_index] == lk_tag);

endmodule

// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
// Responder end of the instruction-fetch interface: a direct-mapped read-only
// I-cache. Hits answer in the same cycle; misses fetch a 256-bit line as a
// 4-beat x 64-bit burst and then hit on the following cycle.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   imem_read, imem_address   : fetch request (held until imem_resp)
//   imem_rdata, imem_resp     : instruction word and response strobe
//   flush                     : one-cycle pulse, invalidate all lines
//   pmem_read, pmem_address   : burst request to memory (line aligned)
//   pmem_rdata, pmem_resp     : burst beats, one pmem_resp pulse per beat
//   perf_hits, perf_misses    : saturating counters, only with ICACHE_PERF_EN
// -----------------------------------------------------------------------------
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int S_INDEX = S_INDEX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        flush,
    output logic        pmem_read,
    output logic [31:0] pmem_address,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    icache_state_t         state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [31:S_OFFSET]    fill_addr_q, fill_addr_d;
    logic                  flush_pend_q, flush_pend_d;

    logic hit;
    logic beat_we;
    logic line_we;
    logic clear_all;
    logic unused_addr_bits;

    assign unused_addr_bits = ^imem_address[1:0];

    icache_datapath #(
        .S_INDEX (S_INDEX)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .lookup_addr    (imem_address[31:2]),
        .lookup_read    (imem_read && (state_q == CHECK)),
        .hit            (hit),
        .rdata          (imem_rdata),
        .beat_we        (beat_we),
        .beat_idx       (beat_q),
        .beat_data      (pmem_rdata),
        .line_we        (line_we),
        .fill_line_addr (fill_addr_q),
        .clear_all      (clear_all)
    );

    assign pmem_address = {fill_addr_q, 5'b0};

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fill_addr_d  = fill_addr_q;
        flush_pend_d = flush_pend_q;
        imem_resp    = 1'b0;
        pmem_read    = 1'b0;
        beat_we      = 1'b0;
        line_we      = 1'b0;
        clear_all    = 1'b0;
        case (state_q)
            CHECK: begin
                beat_d       = 2'd0;
                flush_pend_d = 1'b0;
                if (hit) begin
                    imem_resp = 1'b1;
                end else if (imem_read) begin
                    state_d     = FILL;
                    fill_addr_d = imem_address[31:S_OFFSET];
                end
                // A hit in this cycle is still served from the old contents.
                clear_all = flush;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (pmem_resp) begin
                    beat_we = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'(BURST_LEN - 1)) begin
                        line_we      = 1'b1;
                        clear_all    = flush_pend_q || flush;
                        flush_pend_d = 1'b0;
                        state_d      = CHECK;
                    end
                end
            end
            default: begin
                state_d = CHECK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CHECK;
            beat_q       <= 2'd0;
            fill_addr_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fill_addr_q  <= fill_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef ICACHE_PERF_EN
    // The first response after a fill belongs to the miss, not to a hit.
    logic        just_filled_q, just_filled_d;
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;

    always_comb begin
        just_filled_d = line_we;
        hits_d        = hits_q;
        misses_d      = misses_q;
        if (imem_resp && !just_filled_q && (hits_q != 32'hFFFF_FFFF)) begin
            hits_d = hits_q + 32'd1;
        end
        if ((state_q == CHECK) && (state_d == FILL) && (misses_q != 32'hFFFF_FFFF)) begin
            misses_d = misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            just_filled_q <= 1'b0;
            hits_q        <= '0;
            misses_q      <= '0;
        end else begin
            just_filled_q <= just_filled_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch_responder
// Directed bench for icache_fetch_responder: cold miss, hit, conflict eviction,
// flush in CHECK and mid-fill, reset mid-fill, last set, sequential fetch.
// Perf counter checks are included when ICACHE_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        flush;
    logic        pmem_read;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int checks = 0;
    int errors = 0;

    icache_fetch_responder dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .flush        (flush),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits    (perf_hits),
        .perf_misses  (perf_misses)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: line 0x60 holds word w = w * 0x1111_1111, every other
    // word reads as {16'hC0DE, byte address[15:0]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h3) begin
            return 32'(a[4:2]) * 32'h1111_1111;
        end
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] a, input int k);
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        return {mem_word(base + 32'(8 * k + 4)), mem_word(base + 32'(8 * k))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hit_check(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        imem_read    = 1'b1;
        imem_address = addr;
        #1;
        chk({tag, "_resp"}, imem_resp, 1);
        chk({tag, "_rdata"}, imem_rdata, exp);
        chk({tag, "_pread"}, pmem_read, 0);
    endtask

    // Issue a missing request and feed one full burst. With mid_flush a flush
    // is pulsed in an idle cycle after two beats and the request must re-miss.
    task automatic miss_fill(input logic [31:0] addr, input bit mid_flush,
                             input string tag, input logic [31:0] exp_data);
        imem_read    = 1'b1;
        imem_address = addr;
        #1;
        chk({tag, "_miss"}, imem_resp, 0);
        tick();
        chk({tag, "_pread"}, pmem_read, 1);
        chk({tag, "_paddr"}, pmem_address, {addr[31:5], 5'b0});
        for (int k = 0; k < 4; k++) begin
            if (mid_flush && k == 2) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            pmem_resp  = 1'b1;
            pmem_rdata = beat(addr, k);
            #1;
            chk({tag, "_busy"}, imem_resp, 0);
            tick();
            pmem_resp  = 1'b0;
            pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        #1;
        if (mid_flush) begin
            chk({tag, "_remiss"}, imem_resp, 0);
        end else begin
            chk({tag, "_resp"}, imem_resp, 1);
            chk({tag, "_rdata"}, imem_rdata, exp_data);
            chk({tag, "_pread_off"}, pmem_read, 0);
        end
    endtask

    initial begin
        int bursts;
        int resps;

        rst          = 1'b1;
        imem_read    = 1'b0;
        imem_address = 32'h0;
        flush        = 1'b0;
        pmem_rdata   = 64'h0;
        pmem_resp    = 1'b0;
        repeat (3) tick();
        chk("rst_resp", imem_resp, 0);
        chk("rst_pread", pmem_read, 0);
        chk("rst_rdata_known", $isunknown(imem_rdata), 0);
        rst = 1'b0;
        tick();

        // Cold miss, then hit inside the same line.
        miss_fill(32'h0000_0060, 0, "cold", 32'h0000_0000);
        tick();
        hit_check(32'h0000_0074, "hit74", 32'h5555_5555);
        tick();

        // Conflict eviction in set 3.
        miss_fill(32'h0000_0160, 0, "evict160", 32'hC0DE_0160);
        tick();
        miss_fill(32'h0000_0060, 0, "evict060", 32'h0000_0000);
        tick();

        // Flush in CHECK: same-cycle hit is still served, then a re-miss.
        imem_read    = 1'b1;
        imem_address = 32'h0000_0074;
        flush        = 1'b1;
        #1;
        chk("flush_hit_resp", imem_resp, 1);
        chk("flush_hit_rdata", imem_rdata, 32'h5555_5555);
        tick();
        flush = 1'b0;

        // Stray beat while idle must not advance the beat counter.
        imem_read  = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        pmem_resp  = 1'b0;
        miss_fill(32'h0000_0060, 0, "postflush", 32'h0000_0000);
        tick();
        hit_check(32'h0000_007C, "hit7c", 32'h7777_7777);
        tick();

        // Flush mid-fill: unaligned request, re-miss, second burst.
        miss_fill(32'h0000_0174, 1, "midflush", 32'h0);
        miss_fill(32'h0000_0174, 0, "refill", 32'hC0DE_0174);
        tick();

        // Last set (index 7).
        miss_fill(32'h0000_00FC, 0, "set7", 32'hC0DE_00FC);
        tick();
        hit_check(32'h0000_00E0, "set7hit", 32'hC0DE_00E0);
        tick();

        // Reset after the first beat of a fill abandons the burst.
        imem_read    = 1'b1;
        imem_address = 32'h0000_01E0;
        #1;
        chk("rstfill_miss", imem_resp, 0);
        tick();
        chk("rstfill_pread", pmem_read, 1);
        pmem_resp  = 1'b1;
        pmem_rdata = beat(32'h0000_01E0, 0);
        tick();
        pmem_resp = 1'b0;
        rst       = 1'b1;
        tick();
        chk("rstfill_pread_off", pmem_read, 0);
        chk("rstfill_resp_off", imem_resp, 0);
        rst = 1'b0;
        miss_fill(32'h0000_01E0, 0, "rstfill", 32'hC0DE_01E0);
        tick();

        // Sequential fetch over two lines from a fresh reset.
        imem_read = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
`ifdef ICACHE_PERF_EN
        chk("perf_rst_hits", perf_hits, 0);
        chk("perf_rst_misses", perf_misses, 0);
`endif
        bursts = 0;
        resps  = 0;
        for (int pc = 0; pc < 64; pc += 4) begin
            imem_read    = 1'b1;
            imem_address = 32'(pc);
            #1;
            if (!imem_resp) begin
                bursts++;
                miss_fill(32'(pc), 0, "seqfill", mem_word(32'(pc)));
            end else begin
                chk("seq_rdata", imem_rdata, mem_word(32'(pc)));
            end
            if (imem_resp) begin
                resps++;
            end
            tick();
        end
        imem_read = 1'b0;
        chk("seq_bursts", 64'(bursts), 64'd2);
        chk("seq_resps", 64'(resps), 64'd16);
`ifdef ICACHE_PERF_EN
        #1;
        chk("perf_misses", perf_misses, 2);
        chk("perf_hits", perf_hits, 14);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
